// File: rtl/uart_sensor_frame_rx.sv
// uart_sensor_frame_rx
// Receives 8N1 UART bytes and decodes 4-byte sensor frames of the form
// ID (0xAA lux / 0xBB humidity), value high, value low, 0x0A.
// Ports:
//   clk            - system clock
//   reset          - asynchronous, active-low reset
//   uart_rx_pin    - serial input, idles high, asynchronous to clk
//   sensor_id      - ID of the last good frame
//   sensor_value   - {high, low} of the last good frame
//   frame_valid    - one-cycle strobe per good frame
//   lux_value      - last good lux value
//   humidity_value - last good humidity value
//   frame_err      - one-cycle strobe on a framing, frame or timeout error
//   err_count      - saturating count of frame_err strobes
module uart_sensor_frame_rx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 520800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_pin,
    output logic [7:0]  sensor_id,
    output logic [15:0] sensor_value,
    output logic        frame_valid,
    output logic [15:0] lux_value,
    output logic [15:0] humidity_value,
    output logic        frame_err,
    output logic [7:0]  err_count
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    ID_LUX  = 8'hAA;
    localparam logic [7:0]    ID_HUM  = 8'hBB;
    localparam logic [7:0]    EOF_B   = 8'h0A;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_ID, P_HI, P_LO, P_NL} p_state_t;

    logic          sync1_r, rxs_r;
    rx_state_t     rx_state_r, rx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    shift_r, shift_s;
    logic          byte_stb_s, rx_ferr_s;

    p_state_t      p_state_r, p_state_s;
    logic [7:0]    id_r, id_s, hi_r, hi_s, lo_r, lo_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic [7:0]    sid_s;
    logic [15:0]   sval_s, lux_s, hum_s;
    logic          fv_s, fe_s;
    logic [7:0]    errc_s;

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= uart_rx_pin;
            rxs_r   <= sync1_r;
        end
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= R_IDLE;
            rx_cnt_r   <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
        end
    end

    // Receiver next-state: mid-bit sampling, leaving the stop bit at its
    // midpoint so a zero-gap following start bit is still caught.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r + 1'b1;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        byte_stb_s = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_r)
            R_IDLE: begin
                rx_cnt_s = '0;
                if (!rxs_r) begin
                    bit_cnt_s  = 3'd0;
                    rx_state_s = R_START;
                end else begin
                    rx_state_s = R_IDLE;
                end
            end
            R_START: begin
                if (rx_cnt_r == HALF_M1) begin
                    rx_cnt_s   = '0;
                    // Line back high at mid start bit: glitch, not an error.
                    rx_state_s = rxs_r ? R_IDLE : R_DATA;
                end else begin
                    rx_state_s = R_START;
                end
            end
            R_DATA: begin
                if (rx_cnt_r == BIT_M1) begin
                    rx_cnt_s  = '0;
                    shift_s   = {rxs_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        rx_state_s = R_STOP;
                    end else begin
                        rx_state_s = R_DATA;
                    end
                end else begin
                    rx_state_s = R_DATA;
                end
            end
            R_STOP: begin
                if (rx_cnt_r == BIT_M1) begin
                    rx_cnt_s   = '0;
                    rx_state_s = R_IDLE;
                    if (rxs_r) begin
                        byte_stb_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_state_s = R_STOP;
                end
            end
            default: begin
                rx_cnt_s   = '0;
                rx_state_s = R_IDLE;
            end
        endcase
    end

    // Parser state, partial-frame holding and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state_r      <= P_ID;
            id_r           <= 8'h00;
            hi_r           <= 8'h00;
            lo_r           <= 8'h00;
            tmo_r          <= '0;
            sensor_id      <= 8'h00;
            sensor_value   <= 16'h0000;
            frame_valid    <= 1'b0;
            lux_value      <= 16'h0000;
            humidity_value <= 16'h0000;
            frame_err      <= 1'b0;
            err_count      <= 8'h00;
        end else begin
            p_state_r      <= p_state_s;
            id_r           <= id_s;
            hi_r           <= hi_s;
            lo_r           <= lo_s;
            tmo_r          <= tmo_s;
            sensor_id      <= sid_s;
            sensor_value   <= sval_s;
            frame_valid    <= fv_s;
            lux_value      <= lux_s;
            humidity_value <= hum_s;
            frame_err      <= fe_s;
            err_count      <= errc_s;
        end
    end

    // Parser next-state. A framing error takes precedence over a timeout in
    // the same cycle (one pulse); a received byte beats a timeout.
    always_comb begin
        p_state_s = p_state_r;
        id_s      = id_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        tmo_s     = tmo_r;
        sid_s     = sensor_id;
        sval_s    = sensor_value;
        lux_s     = lux_value;
        hum_s     = humidity_value;
        fv_s      = 1'b0;
        fe_s      = 1'b0;
        if (rx_ferr_s) begin
            fe_s      = 1'b1;
            tmo_s     = '0;
            p_state_s = P_ID;
        end else if (byte_stb_s) begin
            tmo_s = '0;
            case (p_state_r)
                P_ID: begin
                    if (shift_r == ID_LUX || shift_r == ID_HUM) begin
                        id_s      = shift_r;
                        p_state_s = P_HI;
                    end else begin
                        p_state_s = P_ID;
                    end
                end
                P_HI: begin
                    hi_s      = shift_r;
                    p_state_s = P_LO;
                end
                P_LO: begin
                    lo_s      = shift_r;
                    p_state_s = P_NL;
                end
                P_NL: begin
                    if (shift_r == EOF_B) begin
                        fv_s      = 1'b1;
                        sid_s     = id_r;
                        sval_s    = {hi_r, lo_r};
                        p_state_s = P_ID;
                        if (id_r == ID_LUX) begin
                            lux_s = {hi_r, lo_r};
                        end else begin
                            hum_s = {hi_r, lo_r};
                        end
                    end else begin
                        fe_s = 1'b1;
                        // A stray ID byte in the terminator slot starts a new frame.
                        if (shift_r == ID_LUX || shift_r == ID_HUM) begin
                            id_s      = shift_r;
                            p_state_s = P_HI;
                        end else begin
                            p_state_s = P_ID;
                        end
                    end
                end
                default: p_state_s = P_ID;
            endcase
        end else if (p_state_r != P_ID) begin
            if (tmo_r == TMO_M1) begin
                fe_s      = 1'b1;
                tmo_s     = '0;
                p_state_s = P_ID;
            end else begin
                tmo_s = tmo_r + 1'b1;
            end
        end else begin
            tmo_s = '0;
        end
        if (fe_s && err_count != 8'hFF) begin
            errc_s = err_count + 8'd1;
        end else begin
            errc_s = err_count;
        end
    end
endmodule

// File: tb/tb_uart_sensor_frame_rx.sv
// Directed bench for uart_sensor_frame_rx with CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000.
module tb_uart_sensor_frame_rx;
    localparam int CPB = 16;
    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx_pin = 1'b1;
    logic [7:0]  sensor_id;
    logic [15:0] sensor_value;
    logic        frame_valid;
    logic [15:0] lux_value;
    logic [15:0] humidity_value;
    logic        frame_err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int wide_cnt = 0;
    logic fv_prev = 1'b0;

    uart_sensor_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .uart_rx_pin(uart_rx_pin),
        .sensor_id(sensor_id), .sensor_value(sensor_value),
        .frame_valid(frame_valid), .lux_value(lux_value),
        .humidity_value(humidity_value), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Strobe monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (frame_valid && fv_prev) wide_cnt <= wide_cnt + 1;
        fv_prev <= frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_pin = stop;
        repeat (CPB) @(negedge clk);
        uart_rx_pin = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_id"}, 32'(sensor_id), 32'h0);
        check({tag, "_val"}, 32'(sensor_value), 32'h0);
        check({tag, "_lux"}, 32'(lux_value), 32'h0);
        check({tag, "_hum"}, 32'(humidity_value), 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_fe"}, 32'(frame_err), 32'h0);
        check({tag, "_errc"}, 32'(err_count), 32'h0);
    endtask

    initial begin
        // Reset state
        idle(4);
        check_all_zero("rst");
        reset = 1'b1;
        idle(10);

        // Basic lux frame
        send_frame(8'hAA, 8'h01, 8'h2C, 8'h0A);
        idle(20);
        check("t1_fvcnt", 32'(fv_cnt), 32'd1);
        check("t1_id", 32'(sensor_id), 32'hAA);
        check("t1_val", 32'(sensor_value), 32'h012C);
        check("t1_lux", 32'(lux_value), 32'h012C);
        check("t1_hum", 32'(humidity_value), 32'h0);
        check("t1_errc", 32'(err_count), 32'h0);

        // Back-to-back frames with zero gap
        send_frame(8'hBB, 8'h00, 8'h37, 8'h0A);
        send_frame(8'hAA, 8'hFF, 8'hFF, 8'h0A);
        idle(20);
        check("t2_fvcnt", 32'(fv_cnt), 32'd3);
        check("t2_hum", 32'(humidity_value), 32'h0037);
        check("t2_lux", 32'(lux_value), 32'hFFFF);
        check("t2_id", 32'(sensor_id), 32'hAA);

        // Leading junk dropped silently
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        send_frame(8'hBB, 8'h00, 8'h64, 8'h0A);
        idle(20);
        check("t3_fvcnt", 32'(fv_cnt), 32'd4);
        check("t3_val", 32'(sensor_value), 32'h0064);
        check("t3_hum", 32'(humidity_value), 32'h0064);
        check("t3_errc", 32'(err_count), 32'h0);
        check("t3_fecnt", 32'(fe_cnt), 32'd0);

        // Bad terminator then a good humidity frame
        send_frame(8'hAA, 8'h01, 8'h02, 8'h33);
        send_frame(8'hBB, 8'h00, 8'h10, 8'h0A);
        idle(20);
        check("t4_errc", 32'(err_count), 32'd1);
        check("t4_fecnt", 32'(fe_cnt), 32'd1);
        check("t4_fvcnt", 32'(fv_cnt), 32'd5);
        check("t4_hum", 32'(humidity_value), 32'h0010);
        check("t4_lux", 32'(lux_value), 32'hFFFF);

        // Inter-byte timeout
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(1500);
        check("t5_pre_tmo_errc", 32'(err_count), 32'd1);
        idle(700);
        check("t5_tmo_errc", 32'(err_count), 32'd2);
        check("t5_tmo_fecnt", 32'(fe_cnt), 32'd2);
        send_frame(8'hAA, 8'h00, 8'h05, 8'h0A);
        idle(20);
        check("t5_lux", 32'(lux_value), 32'h0005);
        check("t5_fvcnt", 32'(fv_cnt), 32'd6);

        // Framing error (stop bit 0) forces parser back to ID
        send_byte(8'hAA, 1'b1);
        send_byte(8'h12, 1'b0);
        idle(200);
        check("t6_ferr_errc", 32'(err_count), 32'd3);
        send_frame(8'hBB, 8'h00, 8'h01, 8'h0A);
        idle(20);
        check("t6_fvcnt", 32'(fv_cnt), 32'd7);
        check("t6_hum", 32'(humidity_value), 32'h0001);
        check("t6_errc", 32'(err_count), 32'd3);

        // Short low glitch: no byte, no error
        uart_rx_pin = 1'b0;
        idle(3);
        uart_rx_pin = 1'b1;
        idle(300);
        check("t7_glitch_errc", 32'(err_count), 32'd3);
        check("t7_glitch_fvcnt", 32'(fv_cnt), 32'd7);

        // Reset mid-frame, then a clean frame
        send_byte(8'hAA, 1'b1);
        send_byte(8'h12, 1'b1);
        uart_rx_pin = 1'b0;
        idle(40);
        reset = 1'b0;
        idle(3);
        check_all_zero("t8_rst");
        uart_rx_pin = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(50);
        send_frame(8'hBB, 8'h00, 8'h42, 8'h0A);
        idle(20);
        check("t8_fvcnt", 32'(fv_cnt), 32'd8);
        check("t8_hum", 32'(humidity_value), 32'h0042);
        check("t8_lux", 32'(lux_value), 32'h0);
        check("t8_id", 32'(sensor_id), 32'hBB);
        check("t8_errc", 32'(err_count), 32'h0);

        check("fv_width", 32'(wide_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
